// File: rtl/multdiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_unit_if
//  Description : Operand/control/result bundle between the execute stage and
//                the multi-cycle multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  // Pipeline side: issues operands and start pulses, consumes results.
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  // Unit side.
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface : multdiv_unit_if
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_unit
//  Description : Multi-cycle signed multiply / divide unit for the execute
//                stage. Booth multiply (radix-2, or radix-4 when the macro
//                MULTDIV_RADIX4_EN is defined) and non-restoring divide on
//                operand magnitudes with a final quotient sign fix-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic         clock,
  input  wire logic         reset,
  multdiv_unit_if.slave     bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_ITERS = WIDTH / 2;
`else
  localparam int MUL_ITERS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] c_MUL_ITERS = CNT_W'(MUL_ITERS);
  localparam logic [CNT_W-1:0] c_DIV_ITERS = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] c_MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Shared datapath: r_acc is the Booth accumulator or the partial remainder,
  // r_mq the multiplier / quotient shift register, r_mcand the multiplicand
  // or divisor magnitude. Two guard bits on r_acc absorb +/-2M and 2R.
  logic [WIDTH+1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic             r_qm1;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_counter;
  logic             r_neg_q;
  logic             r_div_ovf;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;

  logic             w_start;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH+1:0] w_m_ext;
  logic [WIDTH+1:0] w_booth_add;
  logic [WIDTH+1:0] w_booth_sum;
  logic [WIDTH+1:0] w_mul_acc_nxt;
  logic [WIDTH-1:0] w_mul_mq_nxt;
  logic             w_mul_qm1_nxt;
  logic [2*WIDTH-1:0] w_product;
  logic             w_mul_ovf;
  logic [WIDTH+1:0] w_d_ext;
  logic [WIDTH+1:0] w_div_shift;
  logic [WIDTH+1:0] w_div_sum;
  logic [WIDTH-1:0] w_div_mq_nxt;
  logic [WIDTH-1:0] w_quot;

  // A start pulse in any state (re)launches an operation; multiply wins a tie.
  assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;

  // Magnitudes for the divider; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  assign w_abs_a = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign w_abs_b = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

  assign w_m_ext = {{2{r_mcand[WIDTH-1]}}, r_mcand};
  assign w_d_ext = {2'b00, r_mcand};

  // Booth recoding step and arithmetic right shift of {acc, mq, q-1}.
  always_comb begin
    w_booth_add = '0;
`ifdef MULTDIV_RADIX4_EN
    case ({r_mq[1:0], r_qm1})
      3'b001, 3'b010: w_booth_add = w_m_ext;
      3'b011:         w_booth_add = {w_m_ext[WIDTH:0], 1'b0};
      3'b100:         w_booth_add = ~{w_m_ext[WIDTH:0], 1'b0} + 1'b1;
      3'b101, 3'b110: w_booth_add = ~w_m_ext + 1'b1;
      default:        w_booth_add = '0;
    endcase
    w_booth_sum   = r_acc + w_booth_add;
    w_mul_acc_nxt = {{2{w_booth_sum[WIDTH+1]}}, w_booth_sum[WIDTH+1:2]};
    w_mul_mq_nxt  = {w_booth_sum[1:0], r_mq[WIDTH-1:2]};
    w_mul_qm1_nxt = r_mq[1];
`else
    case ({r_mq[0], r_qm1})
      2'b01:   w_booth_add = w_m_ext;
      2'b10:   w_booth_add = ~w_m_ext + 1'b1;
      default: w_booth_add = '0;
    endcase
    w_booth_sum   = r_acc + w_booth_add;
    w_mul_acc_nxt = {w_booth_sum[WIDTH+1], w_booth_sum[WIDTH+1:1]};
    w_mul_mq_nxt  = {w_booth_sum[0], r_mq[WIDTH-1:1]};
    w_mul_qm1_nxt = r_mq[0];
`endif
  end

  // Full product and overflow: the upper half plus the result sign bit must
  // all agree for the low word to represent the product exactly.
  assign w_product = {r_acc[WIDTH-1:0], r_mq};
  assign w_mul_ovf = !((&w_product[2*WIDTH-1:WIDTH-1]) || (~|w_product[2*WIDTH-1:WIDTH-1]));

  // Non-restoring step: shift in the next dividend bit, add or subtract the
  // divisor depending on the remainder sign, quotient bit = new sign inverted.
  assign w_div_shift  = {r_acc[WIDTH:0], r_mq[WIDTH-1]};
  assign w_div_sum    = r_acc[WIDTH+1] ? (w_div_shift + w_d_ext) : (w_div_shift - w_d_ext);
  assign w_div_mq_nxt = {r_mq[WIDTH-2:0], ~w_div_sum[WIDTH+1]};
  assign w_quot       = r_neg_q ? (~r_mq + 1'b1) : r_mq;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode; iteration count ends MULT/DIV, zero divisor ends DIV early.
  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = bus.ctrl_MULT ? S_MULT : S_DIV;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_IDLE;
        S_MULT: if (r_counter == c_MUL_ITERS) w_state_next = S_DONE;
        S_DIV:  if ((r_mcand == '0) || (r_counter == c_DIV_ITERS)) w_state_next = S_DONE;
        S_DONE: w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result write-back on the DONE entry edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_mq        <= '0;
      r_qm1       <= 1'b0;
      r_mcand     <= '0;
      r_counter   <= '0;
      r_neg_q     <= 1'b0;
      r_div_ovf   <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else if (w_start) begin
      r_acc     <= '0;
      r_qm1     <= 1'b0;
      r_counter <= '0;
      if (bus.ctrl_MULT) begin
        r_mcand   <= bus.data_operandA;
        r_mq      <= bus.data_operandB;
        r_neg_q   <= 1'b0;
        r_div_ovf <= 1'b0;
      end else begin
        r_mcand   <= w_abs_b;
        r_mq      <= w_abs_a;
        r_neg_q   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        r_div_ovf <= (bus.data_operandA == c_MIN_NEG) && (&bus.data_operandB);
      end
    end else begin
      case (r_state)
        S_MULT: begin
          if (r_counter == c_MUL_ITERS) begin
            r_result    <= w_product[WIDTH-1:0];
            r_exception <= w_mul_ovf;
          end else begin
            r_acc     <= w_mul_acc_nxt;
            r_mq      <= w_mul_mq_nxt;
            r_qm1     <= w_mul_qm1_nxt;
            r_counter <= r_counter + 1'b1;
          end
        end
        S_DIV: begin
          if (r_mcand == '0) begin
            r_result    <= '0;
            r_exception <= 1'b1;
          end else if (r_counter == c_DIV_ITERS) begin
            r_result    <= w_quot;
            r_exception <= r_div_ovf;
          end else begin
            r_acc     <= w_div_sum;
            r_mq      <= w_div_mq_nxt;
            r_counter <= r_counter + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = (r_state == S_DONE);
  assign bus.busy           = (r_state == S_MULT) || (r_state == S_DIV);

endmodule : multdiv_unit
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_unit
//  Description : Directed self-checking bench for multdiv_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_EN
  localparam int c_MUL_LAT = 17;
`else
  localparam int c_MUL_LAT = 33;
`endif
  localparam int c_DIV_LAT = 33;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  multdiv_unit_if #(.WIDTH(32)) bus ();

  multdiv_unit #(.WIDTH(32)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for every check.
  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a start pulse sampled on the next rising edge (E0); afterwards the
  // operands are scrambled to show they are not used past capture.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m, input logic d);
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'hDEAD_BEEF;
    bus.data_operandB = 32'h1234_5678;
  endtask

  // Count edges after E0 until RDY is seen; lat = 0 on timeout.
  task automatic wait_rdy(input int max_edges, output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        lat = i;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  // One complete operation with latency, result, flag, busy and pulse width checks.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic m, input logic d, input logic [31:0] exp_res,
                       input logic exp_exc, input int exp_lat);
    int   lat;
    logic bok;
    start_op(a, b, m, d);
    check_value({tag, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
    wait_rdy(100, lat, bok);
    check_value({tag, "_lat"}, lat, exp_lat);
    check_value({tag, "_res"}, bus.data_result, exp_res);
    check_value({tag, "_exc"}, {31'd0, bus.data_exception}, {31'd0, exp_exc});
    check_value({tag, "_busy_run"}, {31'd0, bok}, 32'd1);
    check_value({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clock);
    #1;
    check_value({tag, "_rdy_1cyc"}, {31'd0, bus.data_resultRDY}, 32'd0);
  endtask

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "simulation time limit reached");
  end

  // Directed stimulus.
  initial begin
    logic early_rdy;
    int   lat;
    logic bok;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_value("rst_res",  bus.data_result, 32'd0);
    check_value("rst_exc",  {31'd0, bus.data_exception}, 32'd0);
    check_value("rst_rdy",  {31'd0, bus.data_resultRDY}, 32'd0);
    check_value("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    do_op("mul_7x-3", 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFEB, 1'b0, c_MUL_LAT);
    repeat (3) @(posedge clock);
    #1;
    check_value("idle_hold_res", bus.data_result, 32'hFFFF_FFEB);

    do_op("mul_ovf_16", 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, c_MUL_LAT);
    do_op("mul_ovf_max", 32'h7FFF_FFFF, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, c_MUL_LAT);
    do_op("mul_min_x1", 32'h8000_0000, 32'd1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, c_MUL_LAT);
    do_op("div_-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, c_DIV_LAT);
    do_op("div_100/-7", 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b1, 32'hFFFF_FFF2, 1'b0, c_DIV_LAT);
    do_op("div_-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b1, 32'd14, 1'b0, c_DIV_LAT);
    do_op("div_5/0", 32'd5, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1);
    do_op("div_min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, c_DIV_LAT);

    // Restart: a divide issued at E10 of a multiply replaces it.
    early_rdy = 1'b0;
    start_op(32'd6, 32'd7, 1'b1, 1'b0);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) early_rdy = 1'b1;
    end
    start_op(32'd100, 32'd5, 1'b0, 1'b1);
    wait_rdy(100, lat, bok);
    check_value("restart_no_early_rdy", {31'd0, early_rdy}, 32'd0);
    check_value("restart_lat", lat, c_DIV_LAT);
    check_value("restart_res", bus.data_result, 32'd20);
    check_value("restart_busy_run", {31'd0, bok}, 32'd1);
    @(posedge clock);
    #1;
    check_value("restart_rdy_1cyc", {31'd0, bus.data_resultRDY}, 32'd0);

    do_op("both_ctrl", 32'd6, 32'd7, 1'b1, 1'b1, 32'd42, 1'b0, c_MUL_LAT);

    // Asynchronous reset in the middle of a multiply.
    start_op(32'd3, 32'd5, 1'b1, 1'b0);
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_value("midrst_res",  bus.data_result, 32'd0);
    check_value("midrst_exc",  {31'd0, bus.data_exception}, 32'd0);
    check_value("midrst_rdy",  {31'd0, bus.data_resultRDY}, 32'd0);
    check_value("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    early_rdy = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY || bus.busy) early_rdy = 1'b1;
    end
    check_value("midrst_quiet", {31'd0, early_rdy}, 32'd0);

    do_op("mul_3x4", 32'd3, 32'd4, 1'b1, 1'b0, 32'd12, 1'b0, c_MUL_LAT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_multdiv_unit
`default_nettype wire
